lut_mult_seq_ctrl: RTL and testbench
====================================

// Module: lut_mult_seq_ctrl
// PURPOSE
//  Sequencer that computes a full unsigned WIDTH x WIDTH product by stepping a 2-bit LUT
//  partial-product stage once per cycle (radix-4 shift-and-add) into a 2*WIDTH accumulator.
//  Sits between an operand producer (valid/ready start) and a result consumer (done/ack).
//  Lets one small LUT step serve a wide multiply instead of a full array multiplier.
// PARAMETERS
//  WIDTH   32                   operand width; must be even; STEPS = WIDTH/2
//  CNT_W   $clog2(WIDTH/2)+1    width of step counter and step_count_seq
// PORTS
//  clk_seq          in   1         single clock; all state updates on posedge
//  reset_seq        in   1         synchronous, active-high reset
//  start_seq        in   1         operand valid; accepted when start_seq && in_ready_seq
//  operand_a_seq    in   WIDTH     multiplicand, unsigned
//  operand_b_seq    in   WIDTH     multiplier, unsigned; consumed 2 bits per step, LSBs first
//  in_ready_seq     out  1         combinational: state==IDLE
//  busy_seq         out  1         registered: 1 while in RUN
//  done_seq         out  1         registered: result valid; held until ack_seq
//  ack_seq          in   1         consumer accepts result; honoured only in DONE
//  result_seq       out  2*WIDTH   registered product; stable while done_seq=1
//  step_count_seq   out  CNT_W     LUT steps executed for the current/last operation
// BEHAVIOUR
//  Reset (sync, any state incl. mid-RUN): state=IDLE; result_seq=0; done_seq=0; busy_seq=0;
//   step_count_seq=0; accumulator/shift regs=0. in_ready_seq=1 on the cycle after reset.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start_seq=1 at edge E0: a_sh <= {WIDTH'b0,A}; b_rem <= B; acc <= 0; cnt <= 0;
//   busy_seq <= 1; -> RUN.
//  RUN, each edge: if terminate condition holds: result_seq <= acc; done_seq <= 1;
//   busy_seq <= 0; step_count_seq <= cnt; -> DONE.
//   Else step: d = b_rem[1:0]; pp = d==0 ? 0 : d==1 ? a_sh : d==2 ? a_sh<<1 : (a_sh<<1)+a_sh;
//   acc <= acc + pp; a_sh <= a_sh<<2; b_rem <= b_rem>>2 (zero fill); cnt <= cnt+1.
//  Terminate condition: cnt==STEPS (plus early-term clause, see CONFIGURATION).
//  Width rules: pp, acc, a_sh are 2*WIDTH bits; the product always fits; no overflow or wrap.
//  Latency (no early term): done_seq rises STEPS+1 edges after E0 (17 for WIDTH=32).
//  DONE: done_seq=1 and result_seq held indefinitely; ack_seq=1 -> IDLE, done_seq <= 0.
//   result_seq keeps its value in IDLE until the next completion or reset.
//  start_seq while in RUN/DONE: ignored (in_ready_seq=0); operands are not captured.
//  ack_seq outside DONE: ignored. start_seq+ack_seq in the same DONE cycle: ack honoured,
//   start ignored; a new start is accepted on the next cycle in IDLE.
//  Reset has priority over start_seq/ack_seq on the same edge.
//  Back-to-back throughput: at most 1 operation per STEPS+3 cycles.
// CONFIGURATION
//  `define LUT_MULT_EARLY_TERM_EN
//   Defined: terminate condition is (cnt==STEPS) || (b_rem==0). Remaining zero multiplier
//    digits are skipped; step_count_seq = index of the highest nonzero 2-bit digit of B, plus 1
//    (0 when B=0). Latency = step_count_seq+1 edges after E0.
//   Undefined: always STEPS steps; step_count_seq=STEPS on every completion; fixed latency.
// TESTING
//  1 reset 2 cycles; A=3,B=3, pulse start -> done_seq after 17 edges, result=64'h9,
//    step_count=16.
//  2 A=32'hFFFF_FFFF,B=32'hFFFF_FFFF -> result=64'hFFFF_FFFE_0000_0001; A=0,B=any -> 0.
//  3 start A=5,B=6; hold start with A=7,B=7 during RUN -> result=30; second op not captured.
//  4 start A=9,B=9; assert reset_seq at step 5 -> next cycle done=0, busy=0, result=0,
//    in_ready=1; new op A=2,B=4 -> result=8 with normal latency.
//  5 done held 10 cycles without ack -> result stable; ack+start in same cycle -> IDLE, start
//    ignored; next start A=1,B=1 accepted -> result=1.
//  6 LUT_MULT_EARLY_TERM_EN: B=0 -> done 1 edge, step_count=0, result=0; A=7,B=1 -> 2 edges,
//    step_count=1, result=7; B=32'h8000_0000,A=1 -> 17 edges, result=64'h8000_0000.
//    Without macro, all three take 17 edges with step_count=16.

Source files
------------

// File: rtl/lut_mult_seq_ctrl.sv
// Radix-4 shift-and-add multiplier sequencer: one 2-bit LUT partial-product step per cycle.
// Optional `LUT_MULT_EARLY_TERM_EN stops as soon as the remaining multiplier digits are zero.
module lut_mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic                 clk_seq,
  input  logic                 reset_seq,
  input  logic                 start_seq,
  input  logic [WIDTH-1:0]     operand_a_seq,
  input  logic [WIDTH-1:0]     operand_b_seq,
  output logic                 in_ready_seq,
  output logic                 busy_seq,
  output logic                 done_seq,
  input  logic                 ack_seq,
  output logic [2*WIDTH-1:0]   result_seq,
  output logic [CNT_W-1:0]     step_count_seq
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH / 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_rem_q, b_rem_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      result_q, result_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               term;
  logic [PW-1:0]      pp;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_seq) begin
    if (reset_seq) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_rem_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      step_count_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_rem_q      <= b_rem_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      step_count_q <= step_count_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef LUT_MULT_EARLY_TERM_EN
  assign term = (cnt_q == STEPS) || (b_rem_q == '0);
`else
  assign term = (cnt_q == STEPS);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_seq) state_d = RUN;
      RUN:     if (term)      state_d = DONE;
      DONE:    if (ack_seq)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: every signal assigned below gets a default first; a missing branch would
  // otherwise infer a latch.
  always_comb begin
    pp           = '0;
    a_sh_d       = a_sh_q;
    b_rem_d      = b_rem_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    step_count_d = step_count_q;
    done_d       = done_q;
    busy_d       = busy_q;

    unique case (b_rem_q[1:0])
      2'd0: pp = '0;
      2'd1: pp = a_sh_q;
      2'd2: pp = a_sh_q << 1;
      2'd3: pp = (a_sh_q << 1) + a_sh_q;
    endcase

    unique case (state_q)
      IDLE: if (start_seq) begin
        a_sh_d  = {{WIDTH{1'b0}}, operand_a_seq};
        b_rem_d = operand_b_seq;
        acc_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      RUN: if (term) begin
        result_d     = acc_q;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        step_count_d = cnt_q;
      end else begin
        acc_d   = acc_q + pp;
        a_sh_d  = a_sh_q << 2;
        b_rem_d = b_rem_q >> 2;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: if (ack_seq) done_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    in_ready_seq   = (state_q == IDLE);
    busy_seq       = busy_q;
    done_seq       = done_q;
    result_seq     = result_q;
    step_count_seq = step_count_q;
  end

endmodule

// File: tb/tb_lut_mult_seq_ctrl.sv
// Self-checking bench for lut_mult_seq_ctrl: directed cases plus random operands against
// a product/step-count/latency model; honours `LUT_MULT_EARLY_TERM_EN like the design.
module tb_lut_mult_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH/2) + 1;

  logic               clk_seq = 1'b0;
  logic               reset_seq = 1'b0;
  logic               start_seq = 1'b0;
  logic [WIDTH-1:0]   operand_a_seq = '0;
  logic [WIDTH-1:0]   operand_b_seq = '0;
  logic               in_ready_seq;
  logic               busy_seq;
  logic               done_seq;
  logic               ack_seq = 1'b0;
  logic [2*WIDTH-1:0] result_seq;
  logic [CNT_W-1:0]   step_count_seq;

  int compared = 0;
  int mismatched = 0;

  lut_mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_seq(clk_seq), .reset_seq(reset_seq), .start_seq(start_seq),
    .operand_a_seq(operand_a_seq), .operand_b_seq(operand_b_seq),
    .in_ready_seq(in_ready_seq), .busy_seq(busy_seq), .done_seq(done_seq),
    .ack_seq(ack_seq), .result_seq(result_seq), .step_count_seq(step_count_seq)
  );

  always #5 clk_seq = ~clk_seq;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_seq);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of radix-4 digits the multiplier needs: all of them, or up to the top nonzero one.
  function automatic int ref_steps(input logic [WIDTH-1:0] b);
    int n;
`ifdef LUT_MULT_EARLY_TERM_EN
    n = 0;
    for (int i = 0; i < WIDTH/2; i++)
      if (b[2*i +: 2] != 2'b00) n = i + 1;
`else
    n = WIDTH / 2;
`endif
    return n;
  endfunction

  // Waits for done after the start edge; returns number of edges taken (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 40) begin
      tick();
      edges++;
      if (done_seq === 1'b1) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit do_ack);
    int edges;
    logic [63:0] exp_prod;
    exp_prod = 64'(a) * 64'(b);
    check({tag, ".ready"}, 64'(in_ready_seq), 64'd1);
    start_seq = 1'b1; operand_a_seq = a; operand_b_seq = b;
    tick();
    start_seq = 1'b0;
    operand_a_seq = $urandom; operand_b_seq = $urandom;
    check({tag, ".busy_run"}, 64'(busy_seq), 64'd1);
    wait_done(edges);
    check({tag, ".latency"}, 64'(edges), 64'(ref_steps(b) + 1));
    check({tag, ".result"}, result_seq, exp_prod);
    check({tag, ".steps"}, 64'(step_count_seq), 64'(ref_steps(b)));
    check({tag, ".busy_done"}, 64'(busy_seq), 64'd0);
    if (do_ack) begin
      ack_seq = 1'b1;
      tick();
      ack_seq = 1'b0;
      check({tag, ".done_clr"}, 64'(done_seq), 64'd0);
      check({tag, ".ready_back"}, 64'(in_ready_seq), 64'd1);
      check({tag, ".result_kept"}, result_seq, exp_prod);
    end
  endtask

  initial begin
    int edges;
    logic [63:0] held;
    logic [WIDTH-1:0] ra, rb;

    // Reset state
    reset_seq = 1'b1;
    tick(); tick();
    reset_seq = 1'b0;
    check("rst.ready", 64'(in_ready_seq), 64'd1);
    check("rst.busy", 64'(busy_seq), 64'd0);
    check("rst.done", 64'(done_seq), 64'd0);
    check("rst.result", result_seq, 64'd0);
    check("rst.steps", 64'(step_count_seq), 64'd0);

    // Directed operands, including the width boundary and digit-boundary multipliers
    run_op("small", 32'd3, 32'd3, 1'b1);
    run_op("maxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("a_zero", 32'd0, 32'h1234_5678, 1'b1);
    run_op("b_zero", 32'd5, 32'd0, 1'b1);
    run_op("b_one", 32'd7, 32'd1, 1'b1);
    run_op("b_msb", 32'd1, 32'h8000_0000, 1'b1);

    // start held during RUN with different operands: must not be captured
    start_seq = 1'b1; operand_a_seq = 32'd5; operand_b_seq = 32'd6;
    tick();
    operand_a_seq = 32'd7; operand_b_seq = 32'd7;
    check("hold.ready_run", 64'(in_ready_seq), 64'd0);
    wait_done(edges);
    check("hold.latency", 64'(edges), 64'(ref_steps(32'd6) + 1));
    check("hold.result", result_seq, 64'd30);
    start_seq = 1'b0;
    ack_seq = 1'b1; tick(); ack_seq = 1'b0;
    check("hold.idle_busy", 64'(busy_seq), 64'd0);

    // Synchronous reset in the middle of RUN
    start_seq = 1'b1; operand_a_seq = 32'd9; operand_b_seq = 32'd9;
    tick();
    start_seq = 1'b0;
    repeat (5) tick();
    reset_seq = 1'b1; start_seq = 1'b1; ack_seq = 1'b1;
    tick();
    reset_seq = 1'b0; start_seq = 1'b0; ack_seq = 1'b0;
    check("midrst.done", 64'(done_seq), 64'd0);
    check("midrst.busy", 64'(busy_seq), 64'd0);
    check("midrst.result", result_seq, 64'd0);
    check("midrst.ready", 64'(in_ready_seq), 64'd1);
    check("midrst.steps", 64'(step_count_seq), 64'd0);
    run_op("after_rst", 32'd2, 32'd4, 1'b1);

    // done held without ack; then ack together with start
    run_op("nohack", 32'hDEAD_BEEF, 32'h0000_1235, 1'b0);
    held = 64'(32'hDEAD_BEEF) * 64'(32'h0000_1235);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_done.flag", 64'(done_seq), 64'd1);
      check("hold_done.result", result_seq, held);
    end
    ack_seq = 1'b1; start_seq = 1'b1; operand_a_seq = 32'd11; operand_b_seq = 32'd11;
    tick();
    ack_seq = 1'b0; start_seq = 1'b0;
    check("ackstart.done", 64'(done_seq), 64'd0);
    check("ackstart.busy", 64'(busy_seq), 64'd0);
    check("ackstart.ready", 64'(in_ready_seq), 64'd1);
    tick();
    check("ackstart.still_idle", 64'(in_ready_seq), 64'd1);
    run_op("one_one", 32'd1, 32'd1, 1'b1);

    // Ack outside DONE has no effect
    ack_seq = 1'b1; tick(); ack_seq = 1'b0;
    check("stray_ack.ready", 64'(in_ready_seq), 64'd1);
    check("stray_ack.result", result_seq, 64'd1);

    // Random operands, multiplier magnitudes spread to exercise all digit counts
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) ra = '0;
      run_op("rand", ra, rb, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
